// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// parity codes and the elaboration-time parameter legality check.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int data_bits, input int parity,
                                      input int stop_bits, input int fifo_depth);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (parity == PARITY_NONE || parity == PARITY_EVEN || parity == PARITY_ODD) &&
           (stop_bits == 1 || stop_bits == 2) &&
           (fifo_depth >= 2) && is_pow2(fifo_depth);
  endfunction

endpackage

// File: rtl/uart_tx_buf.sv
// Synchronous transmit FIFO. The read port is registered: pop_data holds the
// most recently popped word until the next pop, so it doubles as the frame word.
module uart_tx_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in uart_tx_buf and are framed
// (start, data LSB first, optional parity, stop bits) one bit per baud tick.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (!params_legal(DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
    $error("uart_tx_fifo: illegal DATA_BITS/PARITY/STOP_BITS/FIFO_DEPTH combination");
  end

  localparam int   IDX_W     = $clog2(DATA_BITS + 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_t            state_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic                 stop_cnt_reg;
  logic                 tx_serial_reg;
  logic                 tx_done_reg;

  logic                 buf_full;
  logic                 buf_empty;
  logic                 buf_push;
  logic                 buf_pop;
  logic [DATA_BITS-1:0] frame_word;
  logic [DATA_BITS-1:0] bit_hit;
  logic                 data_bit;
  logic                 parity_bit;
  logic                 stop_last;
  logic                 frame_start;

  assign tx_ready  = !buf_full;
  assign tx_serial = tx_serial_reg;
  assign tx_done   = tx_done_reg;
  assign tx_busy   = (state_reg != ST_IDLE);

  assign stop_last   = (stop_cnt_reg == STOP_LAST);
  assign frame_start = (state_reg == ST_IDLE) || ((state_reg == ST_STOP) && stop_last);
  assign buf_push    = tx_valid && !buf_full;
  assign buf_pop     = baud_tick && !buf_empty && frame_start;

  uart_tx_buf #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (tx_data),
    .pop       (buf_pop),
    .pop_data  (frame_word),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // One-hot select of the data bit addressed by the running index.
  genvar gi;
  for (gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
    assign bit_hit[gi] = frame_word[gi] && (bit_idx_reg == IDX_W'(gi));
  end
  assign data_bit = |bit_hit;

  assign parity_bit = (PARITY == PARITY_ODD) ? ~(^frame_word) : (^frame_word);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bit_idx_reg   <= '0;
      stop_cnt_reg  <= 1'b0;
      tx_serial_reg <= 1'b1;
      tx_done_reg   <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      if (baud_tick) begin
        case (state_reg)
          ST_IDLE: begin
            if (!buf_empty) begin
              tx_serial_reg <= 1'b0;
              state_reg     <= ST_START;
            end else begin
              tx_serial_reg <= 1'b1;
            end
          end
          ST_START: begin
            tx_serial_reg <= frame_word[0];
            bit_idx_reg   <= IDX_W'(1);
            state_reg     <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_idx_reg < IDX_W'(DATA_BITS)) begin
              tx_serial_reg <= data_bit;
              bit_idx_reg   <= bit_idx_reg + 1'b1;
            end else if (PARITY != PARITY_NONE) begin
              tx_serial_reg <= parity_bit;
              state_reg     <= ST_PARITY;
            end else begin
              tx_serial_reg <= 1'b1;
              stop_cnt_reg  <= 1'b0;
              state_reg     <= ST_STOP;
            end
          end
          ST_PARITY: begin
            tx_serial_reg <= 1'b1;
            stop_cnt_reg  <= 1'b0;
            state_reg     <= ST_STOP;
          end
          ST_STOP: begin
            if (!stop_last) begin
              stop_cnt_reg <= 1'b1;
            end else begin
              // Chain straight into the next start bit so queued frames abut.
              tx_done_reg <= 1'b1;
              if (!buf_empty) begin
                tx_serial_reg <= 1'b0;
                state_reg     <= ST_START;
              end else begin
                state_reg <= ST_IDLE;
              end
            end
          end
          default: begin
            tx_serial_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three transmitter configurations (8N1/4, 7E2/4, 5O1/2) checked every cycle
// against a frame-level queue model, plus literal line patterns.
module tb_uart_tx_fifo;

  localparam int N = 3;
  localparam int DB0 = 8, PA0 = 0, SB0 = 1, DP0 = 4;
  localparam int DB1 = 7, PA1 = 1, SB1 = 2, DP1 = 4;
  localparam int DB2 = 5, PA2 = 2, SB2 = 1, DP2 = 2;

  function automatic int cfg_db(input int i);
    return (i == 0) ? DB0 : (i == 1) ? DB1 : DB2;
  endfunction
  function automatic int cfg_pa(input int i);
    return (i == 0) ? PA0 : (i == 1) ? PA1 : PA2;
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 0) ? SB0 : (i == 1) ? SB1 : SB2;
  endfunction
  function automatic int cfg_dp(input int i);
    return (i == 0) ? DP0 : (i == 1) ? DP1 : DP2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       tx_valid_v [N];
  logic [8:0] tx_data_v  [N];
  logic       ready_v    [N];
  logic       serial_v   [N];
  logic       busy_v     [N];
  logic       done_v     [N];

  uart_tx_fifo #(.DATA_BITS(DB0), .PARITY(PA0), .STOP_BITS(SB0), .FIFO_DEPTH(DP0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(tx_data_v[0][7:0]), .tx_valid(tx_valid_v[0]), .tx_ready(ready_v[0]),
    .tx_serial(serial_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

  uart_tx_fifo #(.DATA_BITS(DB1), .PARITY(PA1), .STOP_BITS(SB1), .FIFO_DEPTH(DP1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(tx_data_v[1][6:0]), .tx_valid(tx_valid_v[1]), .tx_ready(ready_v[1]),
    .tx_serial(serial_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

  uart_tx_fifo #(.DATA_BITS(DB2), .PARITY(PA2), .STOP_BITS(SB2), .FIFO_DEPTH(DP2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(tx_data_v[2][4:0]), .tx_valid(tx_valid_v[2]), .tx_ready(ready_v[2]),
    .tx_serial(serial_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Frame-level model: a word queue plus the list of line bits still to send.
  int q_word     [N][$];
  bit fbits      [N][$];
  bit m_in_frame [N] = '{default: 1'b0};
  bit m_line     [N] = '{default: 1'b1};
  bit m_done     [N] = '{default: 1'b0};
  bit m_can_push [N] = '{default: 1'b0};
  bit m_tick_prev = 1'b0;
  int m_w;

  int done_cnt [N] = '{default: 0};
  bit log_q    [N][$];

  task automatic load_frame(input int i, input int w);
    int ones;
    fbits[i].delete();
    for (int b = 0; b < cfg_db(i); b++) fbits[i].push_back(((w >> b) & 1) == 1);
    if (cfg_pa(i) != 0) begin
      ones = $countones(w);
      fbits[i].push_back((cfg_pa(i) == 1) ? (ones % 2 == 1) : (ones % 2 == 0));
    end
    for (int s = 0; s < cfg_sb(i); s++) fbits[i].push_back(1'b1);
  endtask

  initial forever begin
    @(posedge clk);
    m_tick_prev = baud_tick;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        q_word[i].delete();
        fbits[i].delete();
        m_in_frame[i] = 1'b0;
        m_line[i]     = 1'b1;
        m_done[i]     = 1'b0;
      end else begin
        m_can_push[i] = q_word[i].size() < cfg_dp(i);
        m_done[i] = 1'b0;
        if (baud_tick) begin
          if (m_in_frame[i] && fbits[i].size() > 0) begin
            m_line[i] = fbits[i].pop_front();
          end else begin
            if (m_in_frame[i]) m_done[i] = 1'b1;
            if (q_word[i].size() > 0) begin
              m_w = q_word[i].pop_front();
              load_frame(i, m_w);
              m_line[i] = 1'b0;
              m_in_frame[i] = 1'b1;
            end else begin
              m_in_frame[i] = 1'b0;
              m_line[i] = 1'b1;
            end
          end
        end
        if (tx_valid_v[i] === 1'b1 && m_can_push[i])
          q_word[i].push_back(int'(tx_data_v[i]) & ((1 << cfg_db(i)) - 1));
      end
    end
  end

  // Compare process, done counter and per-tick line log.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (done_v[i] === 1'b1) done_cnt[i]++;
      if (m_tick_prev) log_q[i].push_back(serial_v[i] === 1'b1);
      if (chk_en) begin
        check($sformatf("u%0d.tx_serial", i), 32'(serial_v[i]), 32'(m_line[i]));
        check($sformatf("u%0d.tx_done", i),   32'(done_v[i]),   32'(m_done[i]));
        check($sformatf("u%0d.tx_busy", i),   32'(busy_v[i]),   32'(m_in_frame[i]));
        check($sformatf("u%0d.tx_ready", i),  32'(ready_v[i]),
              32'(q_word[i].size() < cfg_dp(i)));
      end
    end
  end

  int tick_period = 0;
  int tick_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (tick_period == 0) begin
      baud_tick = 1'b0;
      tick_cnt = 0;
    end else begin
      tick_cnt++;
      if (tick_cnt >= tick_period) begin
        tick_cnt = 0;
        baud_tick = 1'b1;
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) log_q[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) tx_valid_v[i] = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
  endtask

  // Skip leading idle ones, then compare the logged line against a literal pattern.
  task automatic check_seq(input int i, input string nm, input string exp);
    int k = 0;
    bit ok = 1'b1;
    string act = "";
    while (k < log_q[i].size() && log_q[i][k]) k++;
    for (int j = 0; j < exp.len(); j++) begin
      if (k + j >= log_q[i].size()) begin
        ok = 1'b0;
        act = {act, "-"};
      end else begin
        act = {act, log_q[i][k + j] ? "1" : "0"};
        if (log_q[i][k + j] != (exp.getc(j) == 8'h31)) ok = 1'b0;
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: line %s, expected %s", nm, act, exp);
  endtask

  int d_snap [N];
  int zeros;
  int waited;
  bit found;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tx_valid_v[i] = 1'b0;
      tx_data_v[i]  = '0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    check("u0.reset_serial", 32'(serial_v[0]), 32'd1);
    check("u0.reset_busy",   32'(busy_v[0]),   32'd0);
    check("u0.reset_done",   32'(done_v[0]),   32'd0);
    check("u2.reset_ready",  32'(ready_v[2]),  32'd1);
    cycles(2);
    rst_n = 1'b1;

    // Single frames: 8N1 0xA5, 7E2 0x03, 5O1 0x00 then 0xFF back to back.
    tick_period = 16;
    cycles(40);
    clear_logs();
    for (int i = 0; i < N; i++) d_snap[i] = done_cnt[i];
    tx_valid_v[0] = 1'b1; tx_data_v[0] = 9'h0A5;
    tx_valid_v[1] = 1'b1; tx_data_v[1] = 9'h003;
    tx_valid_v[2] = 1'b1; tx_data_v[2] = 9'h000;
    cycles(1);
    tx_valid_v[0] = 1'b0; tx_valid_v[1] = 1'b0;
    tx_data_v[2] = 9'h0FF;
    cycles(1);
    tx_valid_v[2] = 1'b0;
    cycles(20 * 16);
    check_seq(0, "u0.frame_A5_8N1", "01010010111");
    check_seq(1, "u1.frame_03_7E2", "011000000111");
    check_seq(2, "u2.frames_00_FF_5O1", "00000011011111011");
    check("u0.done_pulses_A5", 32'(done_cnt[0] - d_snap[0]), 32'd1);
    check("u1.done_pulses_03", 32'(done_cnt[1] - d_snap[1]), 32'd1);
    check("u2.done_pulses_2",  32'(done_cnt[2] - d_snap[2]), 32'd2);

    // Fill with ticks stopped: 4 accepted, 5th dropped, then 4 abutting frames.
    tick_period = 0;
    cycles(2);
    clear_logs();
    d_snap[0] = done_cnt[0];
    tx_valid_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tx_data_v[0] = 9'(8'h11 * (k + 1));
      cycles(1);
      if (k == 2) check("u0.ready_after_3_pushes", 32'(ready_v[0]), 32'd1);
      if (k == 3) check("u0.ready_low_after_4", 32'(ready_v[0]), 32'd0);
      if (k == 4) check("u0.ready_low_after_5", 32'(ready_v[0]), 32'd0);
    end
    tx_valid_v[0] = 1'b0;
    cycles(5);
    check("u0.busy_while_ticks_off", 32'(busy_v[0]), 32'd0);
    tick_period = 16;
    cycles(48 * 16);
    check_seq(0, "u0.four_back_to_back",
              {"0100010001", "0010001001", "0110011001", "0001000101", "111"});
    check("u0.done_pulses_4", 32'(done_cnt[0] - d_snap[0]), 32'd4);

    // Full FIFO with tx_valid held across a STOP-end pop.
    tick_period = 4;
    tx_valid_v[0] = 1'b1;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 500) begin
      tx_data_v[0] = 9'($urandom_range(0, 255));
      cycles(1);
      waited++;
      if (done_v[0] === 1'b1) found = 1'b1;
    end
    check("u0.stop_pop_seen", 32'(found), 32'd1);
    if (found) begin
      check("u0.ready_after_stop_pop", 32'(ready_v[0]), 32'd1);
      check("u0.busy_after_stop_pop",  32'(busy_v[0]),  32'd1);
      cycles(1);
      check("u0.refilled_next_cycle",  32'(ready_v[0]), 32'd0);
    end
    tx_valid_v[0] = 1'b0;

    // Reset during data bit 3 with two words still queued.
    tick_period = 0;
    do_reset();
    tick_period = 8;
    tx_valid_v[0] = 1'b1;
    tx_data_v[0] = 9'h05A; cycles(1);
    tx_data_v[0] = 9'h03C; cycles(1);
    tx_data_v[0] = 9'h081; cycles(1);
    tx_valid_v[0] = 1'b0;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 400) begin
      cycles(1);
      waited++;
      if (m_in_frame[0] && fbits[0].size() == 5) found = 1'b1;
    end
    check("u0.reached_data_bit3", 32'(found), 32'd1);
    d_snap[0] = done_cnt[0];
    rst_n = 1'b0;
    cycles(1);
    check("u0.abort_serial", 32'(serial_v[0]), 32'd1);
    check("u0.abort_busy",   32'(busy_v[0]),   32'd0);
    check("u0.abort_done",   32'(done_v[0]),   32'd0);
    rst_n = 1'b1;
    clear_logs();
    cycles(30 * 8);
    zeros = 0;
    foreach (log_q[0][j]) if (!log_q[0][j]) zeros++;
    check("u0.no_done_after_abort", 32'(done_cnt[0] - d_snap[0]), 32'd0);
    check("u0.line_idle_after_abort", 32'(zeros), 32'd0);
    check("u0.ready_after_abort", 32'(ready_v[0]), 32'd1);

    // Randomised traffic, tick rates and occasional resets.
    tick_period = 0;
    do_reset();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 600 == 0) tick_period = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        tx_valid_v[i] = ($urandom_range(0, 3) == 0);
        tx_data_v[i]  = 9'($urandom_range(0, 511));
      end
      rst_n = ($urandom_range(0, 1999) != 0);
      cycles(1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) tx_valid_v[i] = 1'b0;
    cycles(600);
    for (int i = 0; i < N; i++)
      check($sformatf("u%0d.drained_idle", i), 32'(busy_v[i]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
